branch_predict_resolve: RTL
===========================

Name: branch_predict_resolve

Overview:
Parametrised branch resolution unit for the pipelined CPU. The EX-stage condition evaluator covers the seven existing Branch codes at a configurable datapath width. It adds a per-PC 2-bit saturating-counter branch history table (BHT) that supplies predictions to IF, a mispredict flag that drives the flush logic, and saturating performance counters. BHT reads happen in IF; BHT updates happen when the branch resolves in EX.

Parameters:
DATA_W, 32, width of busA/busB compared by the condition logic
PC_W, 32, width of program counter inputs
BHT_DEPTH, 64, number of BHT entries; power of two, minimum 2
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  pipeline stall; blocks BHT and counter updates
if_pc  input  PC_W  fetch-stage PC used for the prediction lookup
pred_taken  output  1  prediction for if_pc
ex_valid  input  1  EX stage holds a valid instruction
ex_pc  input  PC_W  PC of the instruction in EX
busA  input  DATA_W  first operand
busB  input  DATA_W  second operand
Branch  input  3  condition code
ex_pred_taken  input  1  prediction carried down the pipeline with the EX instruction
Branch_flag  output  1  resolved taken decision
mispredict  output  1  resolved direction differs from prediction
br_total  output  CNT_W  count of resolved conditional branches
br_miss  output  CNT_W  count of mispredicted branches

Behaviour:
- Condition logic is combinational; Branch_flag is forced to 0 when ex_valid=0.
  - 000: 0
  - 001: busA==busB
  - 010: busA!=busB
  - 011: busA[DATA_W-1]==0
  - 100: busA[DATA_W-1]==0 and busA!=0
  - 101: busA[DATA_W-1]==1 or busA==0
  - 110: busA[DATA_W-1]==1
  - 111: 0 (defined, no latch)
- is_br = ex_valid & (Branch!=000) & (Branch!=111).
- mispredict = is_br & (Branch_flag != ex_pred_taken). It is combinational, valid in the same cycle as Branch_flag, and is 0 when is_br=0.
- BHT indexing: IDX_W = log2(BHT_DEPTH). The read index is if_pc[IDX_W+1:2]; the update index is ex_pc[IDX_W+1:2]. Bits [1:0] are ignored. Aliasing is permitted.
- pred_taken = MSB of the 2-bit counter at the read index. The read is combinational.
- BHT update at the rising clk edge when is_br & !stall:
  - Taken: counter +1, saturating at 11.
  - Not taken: counter -1, saturating at 00.
- Read-during-write to the same index: pred_taken reflects the old value. The new value is visible from the next cycle.
- Simultaneous is_br and stall: no BHT update and no counter update. The combinational Branch_flag and mispredict outputs still reflect the inputs.
- Performance counters, updated at the rising edge when is_br & !stall:
  - br_total increments by 1.
  - br_miss increments by 1 only if mispredict is also 1.
  - Both saturate at all-ones and never wrap.
- Reset (async, any time, including mid-update):
  - All BHT entries go to 01 (weakly not-taken), so pred_taken=0 for every PC.
  - br_total and br_miss go to 0.
  - Combinational outputs follow their inputs: Branch_flag and mispredict are 0 when ex_valid=0.
- Latency: decision and mispredict take 0 cycles. The BHT training effect appears 1 cycle after the update edge.

Test Plan:
1. Reset state. Assert rst mid-cycle with if_pc sweeping 0x0..0xFC -> pred_taken=0 for all PCs, br_total=br_miss=0 immediately without waiting for a clk edge.
2. Condition codes. For each Branch 000..111, apply busA/busB ∈ {0, 5, 0xFFFFFFFF, 0x80000000} pairs with ex_valid=1 -> Branch_flag matches the table above. Example: 101 with busA=0 gives 1; 100 with busA=0 gives 0; 111 always gives 0.
3. BHT training. Resolve ex_pc=0x40 taken three times (ex_pred_taken=0) -> counter goes 01→10→11→11; pred_taken at if_pc=0x40 becomes 1 the cycle after the first update; mispredict=1 on the first two resolutions, 0 on the third only if ex_pred_taken=1; br_miss increments only when mispredict=1.
4. Saturation and aliasing. With BHT_DEPTH=64, train 0x40 taken, then resolve 0x140 not-taken twice -> the shared entry goes 11→10→01 and pred_taken at 0x40 returns to 0.
5. Stall and read-during-write. Hold stall=1 with is_br=1 for 5 cycles -> BHT and counters unchanged while Branch_flag still toggles. Then set if_pc=ex_pc=0x80 with an update edge -> pred_taken shows the old value until the following cycle.
6. Counter saturation. Run with CNT_W=4 and 20 mispredicted branches -> br_total=br_miss=15 (4'hF) and they hold there.

Source files
------------

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: EX-stage branch condition evaluation, 2-bit BHT prediction and saturating branch statistics
module branch_predict_resolve #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic [2:0]        Branch,
  input  logic              ex_pred_taken,
  output logic              Branch_flag,
  output logic              mispredict,
  output logic [CNT_W-1:0]  br_total,
  output logic [CNT_W-1:0]  br_miss
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic [1:0] bht_q [BHT_DEPTH];
  logic [1:0] ctr, ctr_d;
  logic [7:0] cond;
  logic neg, zero, is_br, upd, unused_pc;
  logic [IDX_W-1:0] ridx, widx;
  logic [CNT_W-1:0] br_total_q, br_total_d, br_miss_q, br_miss_d;
  assign neg = busA[DATA_W-1];
  assign zero = busA == '0;
  // Indexed by Branch code; codes 000 and 111 never take
  assign cond = {1'b0, neg, neg | zero, !neg & !zero, !neg, busA != busB, busA == busB, 1'b0};
  assign ridx = if_pc[IDX_W+1:2];
  assign widx = ex_pc[IDX_W+1:2];
  assign unused_pc = ^{if_pc[1:0], ex_pc[1:0], if_pc[PC_W-1:IDX_W+2], ex_pc[PC_W-1:IDX_W+2]};
  always_comb begin
    Branch_flag = ex_valid & cond[Branch];
    is_br = ex_valid & (Branch != 3'b000) & (Branch != 3'b111);
    mispredict = is_br & (Branch_flag != ex_pred_taken);
    upd = is_br & !stall;
    ctr = bht_q[widx];
    ctr_d = Branch_flag ? (&ctr ? ctr : ctr + 2'd1) : (|ctr ? ctr - 2'd1 : ctr);
    br_total_d = &br_total_q ? br_total_q : br_total_q + CNT_W'(1);
    br_miss_d = (mispredict & ~&br_miss_q) ? br_miss_q + CNT_W'(1) : br_miss_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      br_total_q <= '0;
      br_miss_q <= '0;
    end else if (upd) begin
      bht_q[widx] <= ctr_d;
      br_total_q <= br_total_d;
      br_miss_q <= br_miss_d;
    end
  end
  assign pred_taken = bht_q[ridx][1];
  assign br_total = br_total_q;
  assign br_miss = br_miss_q;
endmodule
